// File: rtl/bp_me_pkg.sv
// Shared memory-endpoint definitions for the CCE stream multiplexer.
package bp_me_pkg;

  // Beat width of the BedRock stream data path.
  localparam int dword_width_gp = 64;

  // Command-port arbitration policy.
  typedef enum logic [0:0] {
    e_cce_arb_rr    = 1'b0,
    e_cce_arb_fixed = 1'b1
  } bp_cce_arb_mode_e;

endpackage

// File: rtl/bp_cce_mem_tag_fifo.sv
// Source-tag FIFO: records which CCE issued each outstanding memory command
// so in-order responses can be steered back to it.
module bp_cce_mem_tag_fifo
  #(parameter int width_p = 1
  , parameter int depth_p = 4
  )
  (input  logic               clk_i
  , input  logic               reset_n_i
  , input  logic               push_i
  , input  logic [width_p-1:0] data_i
  , input  logic               pop_i
  , output logic [width_p-1:0] head_o
  , output logic               full_o
  , output logic               empty_o
  );

  localparam int ptr_w_lp = (depth_p > 1) ? $clog2(depth_p) : 1;
  localparam int cnt_w_lp = $clog2(depth_p + 1);

  logic [width_p-1:0]  mem_q [depth_p];
  logic [ptr_w_lp-1:0] wr_ptr_q, wr_ptr_d;
  logic [ptr_w_lp-1:0] rd_ptr_q, rd_ptr_d;
  logic [cnt_w_lp-1:0] count_q, count_d;
  logic                do_push, do_pop;

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(depth_p - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == cnt_w_lp'(depth_p));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // Next pointer and occupancy; a simultaneous push and pop leave the count unchanged.
  always_comb begin
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Tag storage; contents are only meaningful below the count, so no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/bp_cce_mem_stream_mux.sv
// Merges per-CCE BedRock stream memory commands onto one memory port with
// burst-locked arbitration, and steers in-order responses back by source tag.
module bp_cce_mem_stream_mux
  import bp_me_pkg::*;
  #(parameter int               num_cce_p      = 2
  , parameter int               header_width_p = 128
  , parameter int               data_width_p   = dword_width_gp
  , parameter int               outstanding_p  = 4
  , parameter bp_cce_arb_mode_e arb_mode_p     = e_cce_arb_rr
  )
  (input  logic                                clk_i
  , input  logic                                reset_n_i

  , input  logic [num_cce_p*header_width_p-1:0] cce_cmd_header_i
  , input  logic [num_cce_p*data_width_p-1:0]   cce_cmd_data_i
  , input  logic [num_cce_p-1:0]                cce_cmd_v_i
  , input  logic [num_cce_p-1:0]                cce_cmd_last_i
  , output logic [num_cce_p-1:0]                cce_cmd_ready_and_o

  , output logic [header_width_p-1:0]           mem_cmd_header_o
  , output logic [data_width_p-1:0]             mem_cmd_data_o
  , output logic                                mem_cmd_v_o
  , output logic                                mem_cmd_last_o
  , input  logic                                mem_cmd_ready_and_i

  , input  logic [header_width_p-1:0]           mem_resp_header_i
  , input  logic [data_width_p-1:0]             mem_resp_data_i
  , input  logic                                mem_resp_v_i
  , input  logic                                mem_resp_last_i
  , output logic                                mem_resp_ready_and_o

  , output logic [num_cce_p*header_width_p-1:0] cce_resp_header_o
  , output logic [num_cce_p*data_width_p-1:0]   cce_resp_data_o
  , output logic [num_cce_p-1:0]                cce_resp_v_o
  , output logic [num_cce_p-1:0]                cce_resp_last_o
  , input  logic [num_cce_p-1:0]                cce_resp_ready_and_i

  , output logic                                error_o
  );

  localparam int lg_cce_lp = (num_cce_p > 1) ? $clog2(num_cce_p) : 1;

  logic                 lock_q, lock_d;
  logic [lg_cce_lp-1:0] owner_q, owner_d;
  logic [lg_cce_lp-1:0] rr_q, rr_d;
  logic                 error_q, error_d;

  logic                 gnt_v;
  logic [lg_cce_lp-1:0] gnt_idx;
  logic [lg_cce_lp-1:0] cand_idx;
  logic                 cmd_fire, tag_push, tag_pop;
  logic                 fifo_full, fifo_empty;
  logic [lg_cce_lp-1:0] fifo_head;

  // Arbiter: locked bursts keep their owner; otherwise pick a requester if a tag slot is free.
  always_comb begin
    gnt_v    = 1'b0;
    gnt_idx  = '0;
    cand_idx = '0;
    if (lock_q) begin
      gnt_v   = 1'b1;
      gnt_idx = owner_q;
    end else if (!fifo_full) begin
      for (int unsigned k = 0; k < num_cce_p; k++) begin
        if (arb_mode_p == e_cce_arb_fixed)
          cand_idx = lg_cce_lp'(k);
        else
          cand_idx = lg_cce_lp'((int'(rr_q) + int'(k)) % num_cce_p);
        if (!gnt_v && cce_cmd_v_i[cand_idx]) begin
          gnt_v   = 1'b1;
          gnt_idx = cand_idx;
        end
      end
    end
  end

  assign mem_cmd_header_o = cce_cmd_header_i[int'(gnt_idx)*header_width_p +: header_width_p];
  assign mem_cmd_data_o   = cce_cmd_data_i[int'(gnt_idx)*data_width_p +: data_width_p];
  assign mem_cmd_last_o   = cce_cmd_last_i[gnt_idx];
  assign mem_cmd_v_o      = reset_n_i & gnt_v & cce_cmd_v_i[gnt_idx];

  assign cmd_fire = mem_cmd_v_o & mem_cmd_ready_and_i;
  assign tag_push = cmd_fire & ~lock_q;

  // Ready is returned only to the granted CCE and never while reset is held.
  always_comb begin
    cce_cmd_ready_and_o = '0;
    if (reset_n_i && gnt_v) cce_cmd_ready_and_o[gnt_idx] = mem_cmd_ready_and_i;
  end

  // Response steering: the FIFO head names the CCE that owns the current response.
  always_comb begin
    cce_resp_v_o         = '0;
    mem_resp_ready_and_o = 1'b0;
    if (!fifo_empty) begin
      cce_resp_v_o[fifo_head] = mem_resp_v_i;
      mem_resp_ready_and_o    = cce_resp_ready_and_i[fifo_head];
    end
  end

  assign cce_resp_header_o = {num_cce_p{mem_resp_header_i}};
  assign cce_resp_data_o   = {num_cce_p{mem_resp_data_i}};
  assign cce_resp_last_o   = {num_cce_p{mem_resp_last_i}};
  assign tag_pop           = mem_resp_v_i & mem_resp_ready_and_o & mem_resp_last_i;
  assign error_o           = error_q;

  // Lock, owner, round-robin pointer and sticky error next-state.
  always_comb begin
    lock_d  = lock_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    error_d = error_q | (mem_resp_v_i & fifo_empty);
    if (cmd_fire) begin
      if (!lock_q) begin
        rr_d = (int'(gnt_idx) == num_cce_p - 1) ? '0 : gnt_idx + 1'b1;
        if (!mem_cmd_last_o) begin
          lock_d  = 1'b1;
          owner_d = gnt_idx;
        end
      end else if (mem_cmd_last_o) begin
        lock_d = 1'b0;
      end
    end
  end

  // Arbitration and error state registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      lock_q  <= 1'b0;
      owner_q <= '0;
      rr_q    <= '0;
      error_q <= 1'b0;
    end else begin
      lock_q  <= lock_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      error_q <= error_d;
    end
  end

  bp_cce_mem_tag_fifo
    #(.width_p(lg_cce_lp)
    , .depth_p(outstanding_p)
    )
    tag_fifo
    (.clk_i     (clk_i)
    , .reset_n_i(reset_n_i)
    , .push_i   (tag_push)
    , .data_i   (gnt_idx)
    , .pop_i    (tag_pop)
    , .head_o   (fifo_head)
    , .full_o   (fifo_full)
    , .empty_o  (fifo_empty)
    );

  // No CCE ever sees a response that has no owning tag.
  a_no_resp_when_empty: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    fifo_empty |-> (cce_resp_v_o == '0));

  // While locked the grant is the owner, and the owner holds until the burst ends.
  a_lock_grant: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    lock_q |-> (gnt_v && gnt_idx == owner_q));
  a_lock_owner_stable: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (lock_q && lock_d) |=> $stable(owner_q));

  // Upstream keeps a command valid until it is accepted.
  for (genvar g = 0; g < num_cce_p; g++) begin : g_cmd_hold
    a_cmd_v_held: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      (cce_cmd_v_i[g] && !cce_cmd_ready_and_o[g]) |=> cce_cmd_v_i[g]);
  end

endmodule
